gs_mem_arbiter: RTL and testbench

- Shares one external 8-bit SRAM port between the General Sound Z80 memory bus and a ROM/sample loader.
- Sequences each access over a fixed number of memory cycles and stalls the GS CPU through its WAIT_n input while the access is pending.
- Sits between the GS core memory interface and the top-level SRAM pins.

---
 rtl/gs_mem_arbiter_if.sv | 29 ++
 rtl/gs_mem_arbiter.sv | 105 ++++++++++
 tb/tb_gs_mem_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gs_mem_arbiter_if.sv
// GS CPU, loader and SRAM pin bundle around the memory arbiter.
// slave = arbiter view, master = the surrounding core/loader/SRAM.
interface gs_mem_arbiter_if #(parameter int AW = 21);
  logic [AW-1:0] gs_a;
  logic [7:0]    gs_do;
  logic [7:0]    gs_di;
  logic          gs_rd_n;
  logic          gs_we_n;
  logic          gs_wait_n;
  logic          ldr_req;
  logic [AW-1:0] ldr_a;
  logic [7:0]    ldr_d;
  logic          ldr_ack;
  logic [AW-1:0] mem_a;
  logic [7:0]    mem_do;
  logic [7:0]    mem_di;
  logic          mem_oe_n;
  logic          mem_we_n;

  modport slave (
    input  gs_a, gs_do, gs_rd_n, gs_we_n, ldr_req, ldr_a, ldr_d, mem_di,
    output gs_di, gs_wait_n, ldr_ack, mem_a, mem_do, mem_oe_n, mem_we_n
  );

  modport master (
    output gs_a, gs_do, gs_rd_n, gs_we_n, ldr_req, ldr_a, ldr_d, mem_di,
    input  gs_di, gs_wait_n, ldr_ack, mem_a, mem_do, mem_oe_n, mem_we_n
  );
endinterface

// File: rtl/gs_mem_arbiter.sv
// Shares one 8-bit SRAM between the GS Z80 bus and a ROM/sample loader.
// GS read data after LAT+2 cycles from strobe edge; GS stalled via gs_wait_n, loader held until ldr_ack.
module gs_mem_arbiter #(
  parameter int AW  = 21,
  parameter int LAT = 2
) (
  input logic         CLK,
  input logic         RESET,
  gs_mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, GS_RUN, LDR_RUN} state_t;

  localparam logic [3:0] CNT_LOAD = 4'(LAT - 1);

  state_t        state;
  logic          gs_act;
  logic          gs_act_d;
  logic          gs_edge;
  logic          gs_pend;
  logic          last_gs;
  logic [AW-1:0] cap_a;
  logic [7:0]    cap_d;
  logic          cap_wr;
  logic          run_wr;
  logic [3:0]    cnt;

  assign gs_act        = ~bus.gs_rd_n | ~bus.gs_we_n;
  assign gs_edge       = gs_act & ~gs_act_d;
  assign bus.gs_wait_n = ~(gs_pend | (state == GS_RUN));

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state        <= IDLE;
      gs_act_d     <= 1'b0;
      gs_pend      <= 1'b0;
      last_gs      <= 1'b0;
      cnt          <= '0;
      cap_a        <= '0;
      cap_d        <= '0;
      cap_wr       <= 1'b0;
      run_wr       <= 1'b0;
      bus.mem_oe_n <= 1'b1;
      bus.mem_we_n <= 1'b1;
      bus.mem_a    <= '0;
      bus.mem_do   <= '0;
      bus.gs_di    <= 8'hFF;
      bus.ldr_ack  <= 1'b0;
    end else begin
      gs_act_d    <= gs_act;
      bus.ldr_ack <= 1'b0;
      case (state)
        IDLE: begin
          // Loader gets one turn ahead of GS right after a GS access.
          if (gs_pend && !(bus.ldr_req && last_gs)) begin
            state        <= GS_RUN;
            gs_pend      <= 1'b0;
            run_wr       <= cap_wr;
            bus.mem_a    <= cap_a;
            bus.mem_do   <= cap_d;
            bus.mem_oe_n <= cap_wr;
            bus.mem_we_n <= ~cap_wr;
            cnt          <= CNT_LOAD;
          end else if (bus.ldr_req) begin
            state        <= LDR_RUN;
            bus.mem_a    <= bus.ldr_a;
            bus.mem_do   <= bus.ldr_d;
            bus.mem_we_n <= 1'b0;
            cnt          <= CNT_LOAD;
          end
        end
        GS_RUN: begin
          if (cnt == 4'd0) begin
            state        <= IDLE;
            bus.mem_oe_n <= 1'b1;
            bus.mem_we_n <= 1'b1;
            last_gs      <= 1'b1;
            if (!run_wr) bus.gs_di <= bus.mem_di;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        LDR_RUN: begin
          if (cnt == 4'd0) begin
            state        <= IDLE;
            bus.mem_we_n <= 1'b1;
            bus.ldr_ack  <= 1'b1;
            last_gs      <= 1'b0;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
      // A new edge wins over the clear on GS_RUN entry so it is not lost.
      if (gs_edge) begin
        gs_pend <= 1'b1;
        cap_a   <= bus.gs_a;
        cap_d   <= bus.gs_do;
        cap_wr  <= ~bus.gs_we_n;
      end
    end
  end

endmodule

// File: tb/tb_gs_mem_arbiter.sv
// Bench for gs_mem_arbiter: directed scenarios with literal expectations plus
// random GS/loader traffic compared each cycle against a transaction-timing model.
module tb_gs_mem_arbiter;
  localparam int AW  = 21;
  localparam int LAT = 2;

  logic CLK   = 1'b0;
  logic RESET = 1'b1;

  gs_mem_arbiter_if #(.AW(AW)) bus ();
  gs_mem_arbiter #(.AW(AW), .LAT(LAT)) dut (.CLK(CLK), .RESET(RESET), .bus(bus));

  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] fill(input int i);
    if (i == 'h4123) return 8'h5A;
    return 8'(i ^ (i >> 7));
  endfunction

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // ---------------- SRAM environment ----------------
  logic [7:0] esram [0:65535];
  initial begin
    for (int i = 0; i < 65536; i++) esram[i] = fill(i);
    forever begin
      @(posedge CLK);
      if (!RESET && !bus.mem_we_n) esram[bus.mem_a[15:0]] = bus.mem_do;
    end
  end
  always @(negedge CLK) bus.mem_di = esram[bus.mem_a[15:0]];

  // ---------------- Reference model ----------------
  // An access is a window of LAT cycles starting at run_start; one idle cycle follows.
  int            cyc, run_start, ack_at;
  bit            run_gs, run_wr, pend, p_wr, prev_act, last_gs;
  logic [AW-1:0] run_a, p_a;
  logic [7:0]    run_d, p_d, m_di;
  logic [7:0]    msram [0:65535];

  function automatic bit busy(input int c);
    return (c >= run_start) && (c < run_start + LAT);
  endfunction

  task automatic model_reset();
    cyc = 0; run_start = -1000; ack_at = -1;
    run_gs = 0; run_wr = 0; pend = 0; p_wr = 0; prev_act = 0; last_gs = 0;
    run_a = '0; run_d = '0; p_a = '0; p_d = '0; m_di = 8'hFF;
  endtask

  task automatic model_step();
    int p;
    bit act;
    p = cyc;
    cyc++;
    act = !bus.gs_rd_n || !bus.gs_we_n;
    if (busy(p)) begin
      if (p == run_start + LAT - 1) begin
        if (run_gs && !run_wr) m_di = msram[run_a[15:0]];
        else msram[run_a[15:0]] = run_d;
        if (!run_gs) ack_at = cyc;
        last_gs = run_gs;
      end
    end else if (pend && !(bus.ldr_req && last_gs)) begin
      run_start = cyc; run_gs = 1; run_wr = p_wr; run_a = p_a; run_d = p_d; pend = 0;
    end else if (bus.ldr_req) begin
      run_start = cyc; run_gs = 0; run_wr = 1; run_a = bus.ldr_a; run_d = bus.ldr_d;
    end
    if (act && !prev_act) begin
      pend = 1; p_a = bus.gs_a; p_d = bus.gs_do; p_wr = !bus.gs_we_n;
    end
    prev_act = act;
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) msram[i] = fill(i);
    model_reset();
    forever begin
      @(posedge CLK or posedge RESET);
      if (RESET) model_reset();
      else model_step();
    end
  end

  always @(negedge CLK) begin
    if (!RESET) begin : cmp
      bit b;
      b = busy(cyc);
      chk("cmp_oe",   bus.mem_oe_n,  !(b && run_gs && !run_wr));
      chk("cmp_we",   bus.mem_we_n,  !(b && (!run_gs || run_wr)));
      chk("cmp_excl", bus.mem_oe_n | bus.mem_we_n, 1);
      chk("cmp_wait", bus.gs_wait_n, !(pend || (b && run_gs)));
      chk("cmp_ack",  bus.ldr_ack,   ack_at == cyc);
      chk("cmp_a",    bus.mem_a,     run_a);
      chk("cmp_do",   bus.mem_do,    run_d);
      chk("cmp_di",   bus.gs_di,     m_di);
    end
  end

  // ---------------- Loader driver ----------------
  task automatic ldr_burst(input int n, input logic [AW-1:0] base, input logic [7:0] d0);
    for (int i = 0; i < n; i++) begin
      int k;
      bus.ldr_req = 1'b1;
      bus.ldr_a   = base + AW'(i);
      bus.ldr_d   = d0 + 8'(i);
      k = 0;
      do begin step(); k++; end while (!bus.ldr_ack && k < 200);
      checks++;
      if (!bus.ldr_ack) begin
        errors++;
        $display("FAIL ldr_ack_timeout: no ack after %0d cycles, required ack", k);
      end
    end
    bus.ldr_req = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1);
  end

  // ---------------- Main sequence ----------------
  initial begin
    int n, nwe, nack, first_ack, last_ack, nb;
    bit ok, spacing_ok, wait_low, prev_we, prev_oe;

    bus.gs_a = '0; bus.gs_do = '0; bus.gs_rd_n = 1'b1; bus.gs_we_n = 1'b1;
    bus.ldr_req = 1'b0; bus.ldr_a = '0; bus.ldr_d = '0;
    RESET = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_oe", bus.mem_oe_n, 1);
    chk("rst_we", bus.mem_we_n, 1);
    chk("rst_wait", bus.gs_wait_n, 1);
    chk("rst_di", bus.gs_di, 8'hFF);
    chk("rst_ack", bus.ldr_ack, 0);
    chk("rst_a", bus.mem_a, 0);
    RESET = 1'b0;
    repeat (2) step();

    // GS read at 0x04123, SRAM holds 0x5A
    step(); bus.gs_a = 21'h04123; bus.gs_rd_n = 1'b0;
    step(); @(negedge CLK);
    chk("rd_t1_wait", bus.gs_wait_n, 0);
    chk("rd_t1_oe", bus.mem_oe_n, 1);
    step(); @(negedge CLK);
    chk("rd_t2_oe", bus.mem_oe_n, 0);
    chk("rd_t2_a", bus.mem_a, 21'h04123);
    step(); @(negedge CLK);
    chk("rd_t3_oe", bus.mem_oe_n, 0);
    step(); @(negedge CLK);
    chk("rd_t4_oe", bus.mem_oe_n, 1);
    chk("rd_t4_di", bus.gs_di, 8'h5A);
    chk("rd_t4_wait", bus.gs_wait_n, 1);
    step(); bus.gs_rd_n = 1'b1;

    // GS write 0xC3 to 0x08000
    step(); bus.gs_a = 21'h08000; bus.gs_do = 8'hC3; bus.gs_we_n = 1'b0;
    nwe = 0; ok = 1;
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      if (!bus.mem_we_n) begin
        nwe++;
        if (bus.mem_a != 21'h08000 || bus.mem_do != 8'hC3) ok = 0;
      end
      if (!bus.mem_oe_n) ok = 0;
      step();
      if (i == 3) bus.gs_we_n = 1'b1;
    end
    chk("wr_we_cycles", nwe, 2);
    chk("wr_addr_data", ok, 1);
    chk("wr_di_kept", bus.gs_di, 8'h5A);
    chk("wr_sram", esram[16'h8000], 8'hC3);

    // Loader burst of four writes
    step();
    nwe = 0; nack = 0; first_ack = -1; last_ack = -1;
    spacing_ok = 1; wait_low = 0; prev_we = 1;
    fork
      ldr_burst(4, 21'h0, 8'h10);
      begin
        for (int i = 1; i <= 18; i++) begin
          @(negedge CLK);
          if (!bus.mem_we_n && prev_we) nwe++;
          prev_we = bus.mem_we_n;
          if (bus.ldr_ack) begin
            nack++;
            if (first_ack < 0) first_ack = i;
            if (last_ack >= 0 && i - last_ack != LAT + 1) spacing_ok = 0;
            last_ack = i;
          end
          if (!bus.gs_wait_n) wait_low = 1;
        end
      end
    join
    chk("ldr_we_pulses", nwe, 4);
    chk("ldr_acks", nack, 4);
    chk("ldr_first_ack", first_ack, 4);
    chk("ldr_spacing", spacing_ok, 1);
    chk("ldr_gs_wait", wait_low, 0);
    for (int i = 0; i < 4; i++) chk("ldr_sram", esram[i], 32'h10 + i);

    // Contention: GS edge during loader, then loader preferred after a GS access
    step(); bus.ldr_req = 1'b1; bus.ldr_a = 21'h00100; bus.ldr_d = 8'h77;
    step(); bus.gs_a = 21'h00200; bus.gs_rd_n = 1'b0;
    @(negedge CLK); chk("ct_c1_we", bus.mem_we_n, 0);
    step(); @(negedge CLK); chk("ct_c2_wait", bus.gs_wait_n, 0);
    step();
    chk("ct_c3_ack", bus.ldr_ack, 1);
    bus.ldr_req = 1'b0;
    @(negedge CLK);
    chk("ct_c3_wait", bus.gs_wait_n, 0);
    chk("ct_c3_oe", bus.mem_oe_n, 1);
    step(); bus.gs_rd_n = 1'b1;
    @(negedge CLK);
    chk("ct_c4_oe", bus.mem_oe_n, 0);
    chk("ct_c4_a", bus.mem_a, 21'h00200);
    step();
    bus.gs_a = 21'h00300; bus.gs_rd_n = 1'b0;
    bus.ldr_req = 1'b1; bus.ldr_a = 21'h00101; bus.ldr_d = 8'h78;
    step(); @(negedge CLK);
    chk("ct_c6_di", bus.gs_di, fill('h200));
    chk("ct_c6_wait", bus.gs_wait_n, 0);
    step(); @(negedge CLK);
    chk("ct_c7_we", bus.mem_we_n, 0);
    chk("ct_c7_oe", bus.mem_oe_n, 1);
    chk("ct_c7_a", bus.mem_a, 21'h00101);
    step();
    step();
    chk("ct_c9_ack", bus.ldr_ack, 1);
    bus.ldr_req = 1'b0;
    @(negedge CLK); chk("ct_c9_wait", bus.gs_wait_n, 0);
    step(); @(negedge CLK);
    chk("ct_c10_oe", bus.mem_oe_n, 0);
    chk("ct_c10_a", bus.mem_a, 21'h00300);
    step(); step(); @(negedge CLK);
    chk("ct_c12_wait", bus.gs_wait_n, 1);
    chk("ct_c12_di", bus.gs_di, fill('h300));
    step(); bus.gs_rd_n = 1'b1;

    // Strobe held low for 20 cycles
    step(); bus.gs_a = 21'h00400; bus.gs_rd_n = 1'b0;
    nb = 0; prev_oe = 1;
    for (int i = 0; i < 24; i++) begin
      @(negedge CLK);
      if (!bus.mem_oe_n && prev_oe) nb++;
      prev_oe = bus.mem_oe_n;
      step();
      if (i == 19) bus.gs_rd_n = 1'b1;
    end
    chk("held_bursts", nb, 1);

    // Random mixed traffic
    fork
      begin : gs_rand
        int r;
        for (int k = 0; k < 60; k++) begin
          repeat ($urandom_range(1, 5)) step();
          bus.gs_a  = AW'($urandom);
          bus.gs_do = 8'($urandom);
          r = $urandom_range(0, 9);
          if (r < 5) bus.gs_rd_n = 1'b0;
          else if (r < 9) bus.gs_we_n = 1'b0;
          else begin bus.gs_rd_n = 1'b0; bus.gs_we_n = 1'b0; end
          repeat ($urandom_range(1, 8)) step();
          bus.gs_rd_n = 1'b1; bus.gs_we_n = 1'b1;
        end
      end
      begin : ldr_rand
        for (int k = 0; k < 15; k++) begin
          repeat ($urandom_range(0, 20)) step();
          ldr_burst($urandom_range(1, 4), AW'($urandom), 8'($urandom));
        end
      end
    join

    // Reset asserted in the middle of a GS read
    repeat (10) step();
    bus.gs_a = 21'h04123; bus.gs_rd_n = 1'b0;
    step(); step();
    #2;
    chk("mrst_pre_oe", bus.mem_oe_n, 0);
    RESET = 1'b1;
    #1;
    chk("mrst_oe", bus.mem_oe_n, 1);
    chk("mrst_we", bus.mem_we_n, 1);
    chk("mrst_wait", bus.gs_wait_n, 1);
    chk("mrst_di", bus.gs_di, 8'hFF);
    bus.gs_rd_n = 1'b1;
    step(); step();
    RESET = 1'b0;
    repeat (5) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
